// File: rtl/descrambler_lock_controller.sv
// descrambler_lock_controller: sync-header frame-lock sequencer for the descrambler.
// Define DESCRAMBLER_LOCK_STATS_EN to add the saturating errorCount port.
module descrambler_lock_controller #(
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int WINDOW       = 32,
  parameter int SLIP_WAIT    = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frameValid,
  input  logic [1:0]  header,
  output logic        deScrambleEnable,
  output logic        bitSlip,
  output logic        locked,
  output logic        dataValid
`ifdef DESCRAMBLER_LOCK_STATS_EN
  ,
  output logic [15:0] errorCount
`endif
);

  localparam int GW = $clog2(LOCK_COUNT + 1);
  localparam int BW = $clog2(UNLOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int SW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    HUNT,
    SLIP,
    VERIFY,
    LOCKED
  } state_t;

  state_t        state;
  logic [GW-1:0] good_cnt;
  logic [BW-1:0] bad_cnt;
  logic [WW-1:0] win_cnt;
  logic [SW-1:0] slip_cnt;
  logic          primed;
  logic          good;

  assign good = header[1] ^ header[0];

  // Lock FSM with registered outputs and all counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state            <= HUNT;
      good_cnt         <= '0;
      bad_cnt          <= '0;
      win_cnt          <= '0;
      slip_cnt         <= '0;
      primed           <= 1'b0;
      deScrambleEnable <= 1'b0;
      bitSlip          <= 1'b0;
      locked           <= 1'b0;
      dataValid        <= 1'b0;
`ifdef DESCRAMBLER_LOCK_STATS_EN
      errorCount       <= '0;
`endif
    end else begin
      bitSlip   <= 1'b0;
      dataValid <= 1'b0;
      case (state)
        HUNT: begin
          if (frameValid) begin
            if (good) begin
              state    <= VERIFY;
              good_cnt <= GW'(1);
            end else begin
              state    <= SLIP;
              bitSlip  <= 1'b1;
              slip_cnt <= '0;
            end
          end
        end
        SLIP: begin
          if (slip_cnt == SW'(SLIP_WAIT - 1)) begin
            state    <= HUNT;
            slip_cnt <= '0;
          end else begin
            slip_cnt <= slip_cnt + 1'b1;
          end
        end
        VERIFY: begin
          if (frameValid) begin
            if (!good) begin
              state    <= SLIP;
              bitSlip  <= 1'b1;
              good_cnt <= '0;
              slip_cnt <= '0;
            end else if (good_cnt == GW'(LOCK_COUNT - 1)) begin
              state            <= LOCKED;
              good_cnt         <= '0;
              bad_cnt          <= '0;
              win_cnt          <= '0;
              primed           <= 1'b0;
              deScrambleEnable <= 1'b1;
              locked           <= 1'b1;
            end else begin
              good_cnt <= good_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (frameValid) begin
            dataValid <= primed;
            primed    <= 1'b1;
`ifdef DESCRAMBLER_LOCK_STATS_EN
            if (!good && errorCount != 16'hFFFF)
              errorCount <= errorCount + 16'd1;
`endif
            if (!good && bad_cnt == BW'(UNLOCK_COUNT - 1)) begin
              state            <= HUNT;
              bad_cnt          <= '0;
              win_cnt          <= '0;
              primed           <= 1'b0;
              deScrambleEnable <= 1'b0;
              locked           <= 1'b0;
            end else if (win_cnt == WW'(WINDOW - 1)) begin
              win_cnt <= '0;
              bad_cnt <= '0;
            end else begin
              win_cnt <= win_cnt + 1'b1;
              if (!good)
                bad_cnt <= bad_cnt + 1'b1;
            end
          end
        end
        default: state <= HUNT;
      endcase
    end
  end

endmodule

// File: tb/tb_descrambler_lock_controller.sv
// tb_descrambler_lock_controller: random and directed stimulus
// against a frame-level reference model of the lock sequencer.
module tb_descrambler_lock_controller;

  localparam int LOCK_N   = 16;
  localparam int UNLOCK_N = 4;
  localparam int WIN_N    = 32;
  localparam int WAIT_N   = 4;

  localparam int M_HUNT   = 0;
  localparam int M_SLIP   = 1;
  localparam int M_VERIFY = 2;
  localparam int M_LOCKED = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       frameValid;
  logic [1:0] header;
  logic       deScrambleEnable;
  logic       bitSlip;
  logic       locked;
  logic       dataValid;
`ifdef DESCRAMBLER_LOCK_STATS_EN
  logic [15:0] errorCount;
`endif

  int n_chk;
  int n_fail;

  int m_mode;
  int m_run;
  int m_wait;
  int m_frames;
  int m_bad;
  int m_err;
  bit e_slip;
  bit e_dv;

  int first_lock;
  int first_dv;
  int slips;
  int pbad;
  logic fv;

  descrambler_lock_controller dut (
    .clock            (clock),
    .reset            (reset),
    .frameValid       (frameValid),
    .header           (header),
    .deScrambleEnable (deScrambleEnable),
    .bitSlip          (bitSlip),
    .locked           (locked),
    .dataValid        (dataValid)
`ifdef DESCRAMBLER_LOCK_STATS_EN
    ,
    .errorCount       (errorCount)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] good_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] bad_hdr();
    return ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_reset();
    m_mode   = M_HUNT;
    m_run    = 0;
    m_wait   = 0;
    m_frames = 0;
    m_bad    = 0;
    m_err    = 0;
    e_slip   = 1'b0;
    e_dv     = 1'b0;
  endtask

  task automatic model_slip();
    m_mode = M_SLIP;
    m_wait = WAIT_N;
    m_run  = 0;
    e_slip = 1'b1;
  endtask

  task automatic model_step(input logic v, input logic [1:0] h);
    bit g;
    g      = (h == 2'b01) || (h == 2'b10);
    e_slip = 1'b0;
    e_dv   = 1'b0;
    if (m_mode == M_SLIP) begin
      m_wait--;
      if (m_wait == 0) m_mode = M_HUNT;
    end else if (v) begin
      if (m_mode == M_HUNT) begin
        if (g) begin
          m_mode = M_VERIFY;
          m_run  = 1;
        end else begin
          model_slip();
        end
      end else if (m_mode == M_VERIFY) begin
        if (g) begin
          m_run++;
          if (m_run == LOCK_N) begin
            m_mode   = M_LOCKED;
            m_frames = 0;
            m_bad    = 0;
          end
        end else begin
          model_slip();
        end
      end else begin
        e_dv = (m_frames > 0);
        if (!g) begin
          m_bad++;
          if (m_err < 65535) m_err++;
        end
        if (m_bad == UNLOCK_N) begin
          m_mode = M_HUNT;
          m_bad  = 0;
        end else if ((m_frames % WIN_N) == WIN_N - 1) begin
          m_bad = 0;
        end
        m_frames++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("locked", locked, m_mode == M_LOCKED);
    chk("enable", deScrambleEnable, m_mode == M_LOCKED);
    chk("bitslip", bitSlip, e_slip);
    chk("datavalid", dataValid, e_dv);
`ifdef DESCRAMBLER_LOCK_STATS_EN
    chk("errcount", errorCount, m_err);
`endif
  endtask

  task automatic cycle(input logic v, input logic [1:0] h);
    frameValid = v;
    header     = h;
    @(posedge clock);
    model_step(v, h);
    #1;
    check_outputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2;
    reset = 1'b1;
  endtask

  task automatic lock_up();
    repeat (LOCK_N) cycle(1'b1, good_hdr());
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    reset      = 1'b0;
    frameValid = 1'b0;
    header     = 2'b00;
    model_reset();
    #6;
    do_reset();

    first_lock = 0;
    first_dv   = 0;
    slips      = 0;
    for (int i = 1; i <= 20; i++) begin
      cycle(1'b1, good_hdr());
      if (locked && first_lock == 0) first_lock = i;
      if (dataValid && first_dv == 0) first_dv = i;
      if (bitSlip) slips++;
    end
    chk("lock_frame", first_lock, 16);
    chk("dv_frame", first_dv, 18);
    chk("no_slip", slips, 0);

    do_reset();
    cycle(1'b1, bad_hdr());
    chk("hunt_slip", bitSlip, 1);
    repeat (WAIT_N) cycle(1'b1, good_hdr());
    repeat (LOCK_N - 1) cycle(1'b1, good_hdr());
    chk("hunt_relock_early", locked, 0);
    cycle(1'b1, good_hdr());
    chk("hunt_relock", locked, 1);

    do_reset();
    cycle(1'b1, bad_hdr());
    do_reset();
    chk("slip_truncated", bitSlip, 0);

    do_reset();
    repeat (10) cycle(1'b1, good_hdr());
    cycle(1'b1, bad_hdr());
    chk("verify_slip", bitSlip, 1);
    chk("verify_nolock", locked, 0);
    repeat (WAIT_N) cycle(1'b0, good_hdr());
    repeat (LOCK_N - 1) cycle(1'b1, good_hdr());
    chk("verify_cleared", locked, 0);

    do_reset();
    lock_up();
    repeat (5) cycle(1'b1, good_hdr());
    repeat (3) cycle(1'b1, bad_hdr());
    chk("three_bad_keep", locked, 1);
    repeat (5) cycle(1'b1, good_hdr());
    cycle(1'b1, bad_hdr());
    chk("fourth_bad_drop", locked, 0);
    chk("fourth_bad_enable", deScrambleEnable, 0);
    repeat (10) cycle(1'b1, good_hdr());

    do_reset();
    lock_up();
    repeat (WIN_N - 3) cycle(1'b1, good_hdr());
    repeat (3) cycle(1'b1, bad_hdr());
    repeat (3) cycle(1'b1, bad_hdr());
    chk("window_keep", locked, 1);
    cycle(1'b1, bad_hdr());
    chk("window_drop", locked, 0);

    do_reset();
    lock_up();
    repeat (2) cycle(1'b1, bad_hdr());
    repeat (WIN_N - 2) cycle(1'b1, good_hdr());
    repeat (2) cycle(1'b1, bad_hdr());
    repeat (WIN_N - 2) cycle(1'b1, good_hdr());
    cycle(1'b1, bad_hdr());
    chk("err5_locked", locked, 1);
`ifdef DESCRAMBLER_LOCK_STATS_EN
    chk("err5_count", errorCount, 5);
`endif
    do_reset();
    chk("err5_reset_locked", locked, 0);

    for (int blk = 0; blk < 8; blk++) begin
      case (blk % 4)
        0:       pbad = 1;
        1:       pbad = 5;
        2:       pbad = 15;
        default: pbad = 40;
      endcase
      repeat (400) begin
        fv = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 99) < pbad)
          cycle(fv, bad_hdr());
        else
          cycle(fv, good_hdr());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
